// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a word-addressed on-chip RAM. Independent read and write
// channels, one outstanding burst each, every burst treated as INCR, SLVERR outside the window.
module axi_ram_slave #(
    parameter int                    AXI_ID_W    = 1,
    parameter int                    AXI_ADDR_W  = 32,
    parameter int                    AXI_DATA_W  = 32,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                    DEPTH_WORDS = 4096
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [AXI_ID_W-1:0]     S_AXI_AWID,
    input  logic [AXI_ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [AXI_DATA_W-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [AXI_ID_W-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [AXI_ID_W-1:0]     S_AXI_ARID,
    input  logic [AXI_ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [AXI_ID_W-1:0]     S_AXI_RID,
    output logic [AXI_DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int RAM_AW = $clog2(DEPTH_WORDS);
    // One extra bit so an address below BASE_ADDR shows up as a huge (out-of-range) index.
    localparam int IDX_W  = AXI_ADDR_W + 1;
    localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH_WORDS);

    logic [AXI_DATA_W-1:0] mem [DEPTH_WORDS];

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_ARSIZE, S_AXI_ARBURST};

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_W-1:0] a);
        logic [IDX_W-1:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return {{OFF_W{diff[IDX_W-1]}}, diff[IDX_W-1:OFF_W]};
    endfunction

    // ---------------- write channel ----------------
    typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t w_state, w_next;

    logic [AXI_ID_W-1:0] w_id;
    logic [IDX_W-1:0]    w_idx;
    logic [7:0]          w_len, w_cnt;
    logic                w_err;
    logic                aw_hs, w_hs, w_final, w_in;

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign w_final = (w_cnt == w_len);
    assign w_in    = (w_idx < DEPTH_L);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) w_state <= W_RST;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_RST:  w_next = W_IDLE;
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_id  <= '0;
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            w_id  <= S_AXI_AWID;
            w_idx <= word_idx(S_AXI_AWADDR);
            w_len <= S_AXI_AWLEN;
            w_cnt <= '0;
            w_err <= 1'b0;
        end else if (w_hs) begin
            w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt + 8'd1;
            // WLAST must be high exactly on the beat we count as final.
            if (!w_in || (S_AXI_WLAST != w_final)) w_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_hs && w_in) begin
            for (int b = 0; b < STRB_W; b++)
                if (S_AXI_WSTRB[b]) mem[w_idx[RAM_AW-1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
    end

    assign S_AXI_BID   = w_id;
    assign S_AXI_BRESP = {w_err, 1'b0};

    // ---------------- read channel ----------------
    typedef enum logic [1:0] {R_RST, R_IDLE, R_BURST} r_state_t;
    r_state_t r_state, r_next;

    logic [AXI_ID_W-1:0]   r_id;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_len;
    logic [8:0]            r_fetch;
    logic                  r_valid, r_last;
    logic [1:0]            r_resp;
    logic [AXI_DATA_W-1:0] r_data;
    logic                  ar_hs, r_more, r_load, r_done;

    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_more = (r_fetch <= {1'b0, r_len});
    // The output register doubles as the RAM read register; refill when empty or draining.
    assign r_load = (r_state == R_BURST) && r_more && (!r_valid || S_AXI_RREADY);
    assign r_done = r_valid && S_AXI_RREADY && r_last;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= R_RST;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        case (r_state)
            R_RST:   r_next = R_IDLE;
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) r_next = R_BURST;
            end
            R_BURST: if (r_done) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_fetch <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_resp  <= '0;
            r_data  <= '0;
        end else begin
            if (ar_hs) begin
                r_id    <= S_AXI_ARID;
                r_idx   <= word_idx(S_AXI_ARADDR);
                r_len   <= S_AXI_ARLEN;
                r_fetch <= '0;
            end
            if (r_load) begin
                r_valid <= 1'b1;
                r_last  <= (r_fetch == {1'b0, r_len});
                if (r_idx < DEPTH_L) begin
                    r_data <= mem[r_idx[RAM_AW-1:0]];
                    r_resp <= 2'b00;
                end else begin
                    r_data <= '0;
                    r_resp <= 2'b10;
                end
                r_idx   <= r_idx + IDX_W'(1);
                r_fetch <= r_fetch + 9'd1;
            end else if (r_valid && S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign S_AXI_RID    = r_id;
    assign S_AXI_RDATA  = r_data;
    assign S_AXI_RRESP  = r_resp;
    assign S_AXI_RLAST  = r_last;
    assign S_AXI_RVALID = r_valid;

endmodule
